store_rmw_narrower: RTL
=======================

Name: store_rmw_narrower

Overview:
- Store-side counterpart of the load-path bit extension: truncates 32-bit register data to byte, halfword or word width for SB/SH/SW.
- Merges the narrow value into the addressed word lane of a word-wide data memory that has no byte enables, using read-modify-write.
- Sits between the multi-cycle control unit / register file B operand and the data memory port.
- Byte ordering is little-endian: lane index = addr[1:0].

Parameters:
- DATA_WIDTH, 32, memory word and register width; fixed at 32 (four byte lanes).
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  1  store request present.
- req_ready  output  1  block can accept a request (IDLE only).
- req_addr  input  ADDR_WIDTH  byte address of the store.
- req_data  input  DATA_WIDTH  register data; only the low 8/16/32 bits are used according to req_size.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- mem_addr  output  ADDR_WIDTH  word-aligned address ({req_addr[ADDR_WIDTH-1:2], 2'b00}), held from accept until the operation completes.
- mem_rd_en  output  1  memory read strobe.
- mem_rd_data  input  DATA_WIDTH  read data, valid exactly one cycle after mem_rd_en.
- mem_wr_en  output  1  memory write strobe.
- mem_wr_data  output  DATA_WIDTH  full word to write.
- done  output  1  one-cycle pulse when the store completes.
- misaligned  output  1  one-cycle pulse for a misaligned or illegal request; no memory access occurs.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state goes to IDLE.
  - req_ready=1; mem_rd_en, mem_wr_en, done and misaligned = 0; mem_addr and mem_wr_data = 0.
  - Reset asserted in any state aborts the operation. No write is issued on the cycle after reset.
- States: IDLE, RD_REQ, RD_WAIT, WR, DONE, ERR.
- IDLE:
  - req_ready=1. A request is accepted when req_valid & req_ready.
  - On accept, latch addr, size and truncated data: byte = req_data[7:0], half = req_data[15:0].
  - Alignment rules:
    - byte: any address.
    - half: addr[0]=0.
    - word: addr[1:0]=0.
    - size 11: always illegal.
  - Next state: illegal or misaligned -> ERR; word -> WR (no read); byte or half -> RD_REQ.
- RD_REQ: mem_rd_en=1 for exactly one cycle -> RD_WAIT.
- RD_WAIT: capture mem_rd_data as the old word -> WR.
- WR:
  - mem_wr_en=1 for exactly one cycle.
  - mem_wr_data: byte replaces lane addr[1:0]; half replaces lanes {addr[1],0} and {addr[1],1}; word = latched data.
  - All other lanes equal the captured old word, bit-exact.
  - -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- ERR: misaligned=1 for one cycle, no rd/wr strobes -> IDLE.
- Latency, counting the accept edge as cycle 0:
  - word: mem_wr_en in cycle 1, done in cycle 2.
  - byte/half: mem_rd_en in cycle 1, capture in cycle 2, mem_wr_en in cycle 3, done in cycle 4.
  - misaligned: pulse in cycle 1.
- req_ready=0 in all non-IDLE states; req_valid and input changes while busy are ignored.
- A new request can be accepted in the cycle after done or misaligned (IDLE).
- mem_rd_en and mem_wr_en are never asserted in the same cycle.
- Upper bits of req_data beyond the store size never reach memory.

Test Plan:
- Mem[0x10]=0xAABBCCDD; SB addr 0x11, data 0x12345678 -> rd_en cycle 1, wr_en cycle 3 with mem_addr 0x10, mem_wr_data 0xAABB78DD, done cycle 4.
- Mem[0x10]=0xAABBCCDD; SH addr 0x12, data 0xFFFF1234 -> mem_wr_data 0x1234CCDD; SB at 0x13 with data 0x00000099 -> 0x99BBCCDD.
- SW addr 0x10, data 0xCAFEF00D -> no rd_en, wr_en cycle 1 with 0xCAFEF00D, done cycle 2.
- SH at 0x13, SW at 0x12 and size 11 at 0x10 -> misaligned pulse cycle 1 each, mem_rd_en and mem_wr_en never asserted, memory unchanged.
- SB accepted, rst_n=0 during RD_WAIT -> next cycle IDLE, req_ready=1, no mem_wr_en; following SB completes normally.
- Back-to-back stores with req_valid held high -> second request accepted only in the cycle after done; req_valid pulses while busy have no effect.

Source files
------------

// File: rtl/store_rmw_narrower.sv
// Store-side narrowing unit: truncates register data to SB/SH/SW width and merges it
// into a word-wide memory without byte enables using a read-modify-write sequence.
module store_rmw_narrower #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [1:0]            req_size,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  done,
  output logic                  misaligned
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR, DONE, ERR
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_t;

  state_t                state;
  size_t                 size_q;
  logic [1:0]            lane_q;
  logic [15:0]           data_q;
  logic                  req_bad;
  size_t                 req_sz;
  logic [DATA_WIDTH-1:0] merged;

  assign req_sz = size_t'(req_size);

  always_comb begin
    req_bad = 1'b0;
    unique case (req_sz)
      SZ_BYTE: req_bad = 1'b0;
      SZ_HALF: req_bad = req_addr[0];
      SZ_WORD: req_bad = (req_addr[1:0] != 2'b00);
      SZ_BAD:  req_bad = 1'b1;
    endcase
  end

  // Old word from memory with only the addressed lane(s) replaced.
  always_comb begin
    merged = mem_rd_data;
    if (size_q == SZ_BYTE)
      merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
    else
      merged[{lane_q[1], 4'b0000} +: 16] = data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: synchronous reset clears every register, including the datapath, so
      // nothing from an aborted store can leak into a later write.
      state       <= IDLE;
      req_ready   <= 1'b1;
      mem_addr    <= '0;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= '0;
      done        <= 1'b0;
      misaligned  <= 1'b0;
      size_q      <= SZ_BYTE;
      lane_q      <= 2'b00;
      data_q      <= '0;
    end else begin
      // NOTE: strobes default low each cycle so every pulse lasts exactly one clock;
      // all state uses non-blocking assignments so outputs are clean registers.
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            lane_q    <= req_addr[1:0];
            size_q    <= req_sz;
            data_q    <= (req_sz == SZ_BYTE) ? {8'h00, req_data[7:0]} : req_data[15:0];
            if (req_bad) begin
              state      <= ERR;
              misaligned <= 1'b1;
            end else if (req_sz == SZ_WORD) begin
              state       <= WR;
              mem_wr_en   <= 1'b1;
              mem_wr_data <= req_data;
            end else begin
              state     <= RD_REQ;
              mem_rd_en <= 1'b1;
            end
          end
        end
        RD_REQ:  state <= RD_WAIT;
        RD_WAIT: begin
          state       <= WR;
          mem_wr_en   <= 1'b1;
          mem_wr_data <= merged;
        end
        WR: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE, ERR: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
